bypass_sel_stage: RTL and testbench

Parametrised N-input operand-select stage with a registered output, used for the operand bypass/forwarding paths of both issue lanes. It selects one of NUM_IN flattened input words by a binary select, then captures the result in a single pipeline register under a valid/ready handshake with stall and flush. Out-of-range selects force a zero result, raise a flag, and increment a saturating error counter for debug.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/mux_n_comb.sv | 22 ++
 rtl/bypass_sel_stage.sv | 56 +++++
 tb/tb_bypass_sel_stage.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath width and lane bypass select encodings
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam logic [1:0] SEL_RF    = 2'd0;
    localparam logic [1:0] SEL_EXMEM = 2'd1;
    localparam logic [1:0] SEL_MEMWB = 2'd2;
    localparam logic [1:0] SEL_XLANE = 2'd3;
endpackage

// File: rtl/mux_n_comb.sv
// mux_n_comb: combinational NUM_IN-way word selector, zero result and flag on out-of-range select
module mux_n_comb #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        word,
    output logic                    bad
);
    always_comb begin
        word = '0;
        bad  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == k[SEL_W-1:0]) begin
                word = data[k*WIDTH +: WIDTH];
                bad  = 1'b0;
            end
        end
    end
endmodule

// File: rtl/bypass_sel_stage.sv
// bypass_sel_stage: operand select with one registered handshake stage and saturating bad-select counter
module bypass_sel_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int NUM_IN    = 3,
    parameter int SEL_W     = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sel_err,
    output logic [ERR_CNT_W-1:0]    err_count
);
    if (NUM_IN < 2 || NUM_IN > 16 || (1 << SEL_W) < NUM_IN) begin : g_bad_params
        $error("bypass_sel_stage: illegal NUM_IN/SEL_W combination");
    end
    logic [WIDTH-1:0] sel_word;
    logic             sel_bad;
    logic             accept;
    mux_n_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_mux (
        .data(in_data),
        .sel (in_sel),
        .word(sel_word),
        .bad (sel_bad)
    );
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_sel_err <= 1'b0;
            err_count   <= '0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_sel_err <= 1'b0;
        end else if (accept) begin
            out_data    <= sel_word;
            out_sel_err <= sel_bad;
            out_valid   <= 1'b1;
            err_count   <= (sel_bad && ~&err_count) ? err_count + ERR_CNT_W'(1) : err_count;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
            out_sel_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bypass_sel_stage.sv
// tb_bypass_sel_stage: scoreboard bench for the registered operand-select stage
module tb_bypass_sel_stage;
    localparam int W = 32;
    localparam int N = 3;
    typedef struct packed {
        logic [W-1:0] d;
        logic         e;
    } beat_t;
    logic          clk = 1'b0;
    logic          reset;
    logic [N*W-1:0] in_data;
    logic [1:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sel_err;
    logic [7:0]    err_count;
    logic [W-1:0]  words [N];
    beat_t         q [$];
    int            err_m;
    int            n_tests = 0;
    int            n_fail = 0;
    bypass_sel_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sel_err(out_sel_err),
        .err_count  (err_count)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic cyc(input logic v, input logic [1:0] s, input logic r, input logic f, input logic rst);
        logic  rdy_m;
        beat_t b;
        in_valid  = v;
        in_sel    = s;
        out_ready = r;
        flush     = f;
        reset     = rst;
        #1;
        rdy_m = (q.size() == 0) || r;
        if (!rst) check("in_ready", 32'(in_ready), 32'(rdy_m));
        if (rst) begin
            q.delete();
            err_m = 0;
        end else if (f) begin
            q.delete();
        end else begin
            if (q.size() != 0 && r) void'(q.pop_front());
            if (v && rdy_m) begin
                b.d = (int'(s) < N) ? words[s] : '0;
                b.e = (int'(s) >= N);
                q.push_back(b);
                if (b.e && err_m != 255) err_m++;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_data", out_data, q[0].d);
            check("out_sel_err", 32'(out_sel_err), 32'(q[0].e));
        end else begin
            check("out_sel_err_idle", 32'(out_sel_err), 32'd0);
            if (rst) check("out_data_rst", out_data, 32'd0);
        end
        check("err_count", 32'(err_count), 32'(err_m));
    endtask
    initial begin
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        in_data  = {words[2], words[1], words[0]};
        err_m    = 0;
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 1);
        cyc(1, 1, 1, 0, 0);
        check("basic_b", out_data, 32'h22222222);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 2, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 2, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0);
            check("stall_data", out_data, 32'h33333333);
        end
        cyc(1, 0, 1, 0, 0);
        check("after_stall_a", out_data, 32'h11111111);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 3, 1, 0, 0);
        check("oob_count1", 32'(err_count), 32'd1);
        for (int i = 0; i < 299; i++) cyc(1, 3, 1, 0, 0);
        check("oob_sat_flag", 32'(out_sel_err), 32'd1);
        cyc(0, 0, 1, 0, 0);
        check("oob_sat", 32'(err_count), 32'd255);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 1, 0);
        check("flush_valid", 32'(out_valid), 32'd0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 2, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        check("rst_stall_cnt", 32'(err_count), 32'd0);
        cyc(1, 1, 1, 0, 0);
        check("post_rst_b", out_data, 32'h22222222);
        for (int i = 0; i < 60; i++)
            cyc(1'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
        cyc(1, 3, 1, 1, 1);
        cyc(0, 0, 1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
